// File: rtl/dense2sparse_pkg.sv
// Shared sizing, FSM encoding and last-word mask for the dense-to-sparse converter.
package dense2sparse_pkg;
  localparam int R          = 10163;
  localparam int G_ADDR_W   = 8;
  localparam int G_DAT_W    = 64;
  localparam int H_ADDR_W   = 7;
  localparam int H_DAT_W    = 14;
  localparam int WEIGHT     = 71;
  localparam int RD_LAT     = 2;
  localparam int NWORDS     = (R + 63) / 64;
  localparam int LAST_VALID = R - 64 * (NWORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_SCAN, S_FIN} state_t;

  // Offset 0 is the MSB, so the valid bits of the last word are the top LAST_VALID bits.
  function automatic logic [63:0] last_mask();
    return ~(64'hFFFF_FFFF_FFFF_FFFF >> LAST_VALID);
  endfunction
endpackage

// File: rtl/dense2sparse_lead_one_enc64.sv
// Combinational MSB-first leading-one encoder: idx is the offset of the highest set bit.
module lead_one_enc64 (
  input  logic [63:0] d,
  output logic [5:0]  idx,
  output logic        any
);
  always_comb begin
    idx = '0;
    any = |d;
    // Ascending loop: the highest set bit is the last to assign.
    for (int i = 0; i < 64; i++)
      if (d[i]) idx = 6'(63 - i);
  end
endmodule

// File: rtl/dense2sparse.sv
// Walks the dense polynomial word by word and writes ascending set-bit positions to the sparse RAM.
module dense2sparse
  import dense2sparse_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic [H_ADDR_W:0]   wt_cnt,
  output logic                err_ovf,
  output logic [G_ADDR_W-1:0] h_dsn_addra,
  input  logic [G_DAT_W-1:0]  h_dsn_dina,
  output logic [H_ADDR_W-1:0] h_spa_addra,
  output logic                h_spa_wea,
  output logic [H_DAT_W-1:0]  h_spa_douta
);
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0]       LAT_LAST = LW'(RD_LAT - 1);
  localparam logic [G_ADDR_W-1:0] W_LAST   = G_ADDR_W'(NWORDS - 1);
  localparam logic [H_ADDR_W:0]   WT_MAX   = (H_ADDR_W + 1)'(WEIGHT);

  state_t              state;
  logic [G_ADDR_W-1:0] w;
  logic [63:0]         word_q;
  logic [LW-1:0]       lat_cnt;
  logic [5:0]          lo_idx;
  logic                lo_any;
  logic [63:0]         word_rem;
  logic                emit;

  lead_one_enc64 u_lod (.d(word_q), .idx(lo_idx), .any(lo_any));

  assign word_rem    = word_q & ~(64'h8000_0000_0000_0000 >> lo_idx);
  assign emit        = (state == S_SCAN) && lo_any && (wt_cnt < WT_MAX);
  assign h_spa_wea   = emit;
  assign h_spa_addra = emit ? wt_cnt[H_ADDR_W-1:0] : '0;
  assign h_spa_douta = emit ? {w[H_DAT_W-7:0], lo_idx} : '0;
  assign h_dsn_addra = w;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      w       <= '0;
      word_q  <= '0;
      lat_cnt <= '0;
      wt_cnt  <= '0;
      err_ovf <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            wt_cnt  <= '0;
            err_ovf <= 1'b0;
            w       <= '0;
            busy    <= 1'b1;
            state   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          lat_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            word_q <= (w == W_LAST) ? (h_dsn_dina & last_mask()) : h_dsn_dina;
            state  <= S_SCAN;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        S_SCAN: begin
          if (lo_any) begin
            word_q <= word_rem;
            // Past capacity the bit is still consumed so latency depends on data only.
            if (emit) wt_cnt <= wt_cnt + 1'b1;
            else      err_ovf <= 1'b1;
          end
          if (!lo_any || word_rem == '0) begin
            if (w == W_LAST) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_FIN;
            end else begin
              w     <= w + 1'b1;
              state <= S_ISSUE;
            end
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dense2sparse.sv
// Directed bench for dense2sparse: table of single-word patterns plus overflow, reset and busy-start sequences.
module tb_dense2sparse;
  localparam int R = 10163;
  localparam int NW = 159;
  localparam int CAP = 71;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, err_ovf, h_spa_wea;
  logic [7:0]  wt_cnt;
  logic [7:0]  h_dsn_addra;
  logic [63:0] h_dsn_dina;
  logic [6:0]  h_spa_addra;
  logic [13:0] h_spa_douta;

  logic [63:0] mem [0:255];
  logic [63:0] d1;

  int errors = 0;
  int checks = 0;
  int wr_addr[$];
  int wr_data[$];
  int exp_q[$];
  int exp_tot, exp_lat;

  typedef struct {
    int          widx;
    logic [63:0] val;
    int          n;
    int          first;
    int          last;
    int          lat;
  } vec_t;
  vec_t tbl[5];

  always #5 clk = ~clk;

  dense2sparse dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .wt_cnt(wt_cnt), .err_ovf(err_ovf), .h_dsn_addra(h_dsn_addra),
    .h_dsn_dina(h_dsn_dina), .h_spa_addra(h_spa_addra),
    .h_spa_wea(h_spa_wea), .h_spa_douta(h_spa_douta)
  );

  // Dense RAM with two-cycle read latency.
  always @(posedge clk) begin
    d1         <= mem[h_dsn_addra];
    h_dsn_dina <= d1;
  end

  always @(negedge clk)
    if (h_spa_wea) begin
      wr_addr.push_back(int'(h_spa_addra));
      wr_data.push_back(int'(h_spa_douta));
    end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = '0;
  endtask

  task automatic set_pos(input int p);
    mem[p / 64][63 - (p % 64)] = 1'b1;
  endtask

  // Reference: every valid set bit in ascending position order, capped at capacity.
  task automatic build_exp();
    int pop;
    exp_q.delete();
    exp_tot = 0;
    exp_lat = 1;
    for (int w = 0; w < NW; w++) begin
      pop = 0;
      for (int o = 0; o < 64; o++)
        if (w * 64 + o < R && mem[w][63 - o]) begin
          pop++;
          exp_tot++;
          if (exp_q.size() < CAP) exp_q.push_back(w * 64 + o);
        end
      exp_lat += 3 + ((pop > 0) ? pop : 1);
    end
  endtask

  task automatic run(input string nm, input bit poke, output int lat);
    int bad;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 1;
    chk({nm, " busy"}, int'(busy), 1);
    while (!done && lat < 5000) begin
      start = (poke && lat == 100) ? 1'b1 : 1'b0;
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    chk({nm, " done seen"}, int'(done), 1);
    chk({nm, " latency"}, lat, exp_lat);
    chk({nm, " busy at done"}, int'(busy), 0);
    chk({nm, " wt_cnt"}, int'(wt_cnt), exp_q.size());
    chk({nm, " err_ovf"}, int'(err_ovf), (exp_tot > CAP) ? 1 : 0);
    chk({nm, " writes"}, wr_data.size(), exp_q.size());
    bad = 0;
    for (int i = 0; i < wr_data.size() && i < exp_q.size(); i++)
      if (wr_addr[i] != i || wr_data[i] != exp_q[i]) bad++;
    chk({nm, " entry errors"}, bad, 0);
    @(negedge clk);
    chk({nm, " done one cycle"}, int'(done), 0);
  endtask

  initial begin
    int lat, p, n0;
    tbl[0] = '{0,   64'h8000_0000_0000_0000, 1,  16'h0000, 16'h0000, 637};
    tbl[1] = '{158, 64'h0000_0000_0000_2000, 1,  16'h27B2, 16'h27B2, 637};
    tbl[2] = '{158, 64'hFFFF_FFFF_FFFF_FFFF, 51, 16'h2780, 16'h27B2, 687};
    tbl[3] = '{5,   64'hFFFF_FFFF_FFFF_FFFF, 64, 320,      383,      700};
    tbl[4] = '{10,  64'h0000_0000_0000_0001, 1,  703,      703,      637};

    clear_mem();
    #12;
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset wt_cnt", int'(wt_cnt), 0);
    chk("reset err_ovf", int'(err_ovf), 0);
    chk("reset wea", int'(h_spa_wea), 0);
    chk("reset dsn addr", int'(h_dsn_addra), 0);
    @(negedge clk); rst = 1'b0;

    for (int t = 0; t < 5; t++) begin
      clear_mem();
      mem[tbl[t].widx] = tbl[t].val;
      build_exp();
      run($sformatf("vec%0d", t), 1'b0, lat);
      chk($sformatf("vec%0d count", t), wr_data.size(), tbl[t].n);
      chk($sformatf("vec%0d lat tbl", t), lat, tbl[t].lat);
      if (wr_data.size() > 0) begin
        chk($sformatf("vec%0d first", t), wr_data[0], tbl[t].first);
        chk($sformatf("vec%0d last", t), wr_data[wr_data.size() - 1], tbl[t].last);
      end else begin
        chk($sformatf("vec%0d nonempty", t), 0, 1);
      end
    end

    // 71 then 72 distinct random positions.
    clear_mem();
    for (int k = 0; k < CAP + 1; k++) begin
      do p = int'($urandom_range(R - 1, 0)); while (mem[p / 64][63 - (p % 64)]);
      set_pos(p);
      if (k == CAP - 1) begin
        build_exp();
        run("rand71", 1'b0, lat);
        chk("rand71 wt_cnt", int'(wt_cnt), CAP);
      end
    end
    build_exp();
    run("rand72", 1'b0, lat);
    chk("rand72 err_ovf", int'(err_ovf), 1);
    chk("rand72 writes", wr_data.size(), CAP);

    // Reset during a burst of writes.
    clear_mem();
    mem[5] = '1;
    wr_addr.delete();
    wr_data.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 200 && wr_data.size() < 5; c++) @(negedge clk);
    chk("pre-reset writes", int'(wr_data.size() >= 5), 1);
    #2 rst = 1'b1;
    #1;
    chk("rst wea", int'(h_spa_wea), 0);
    chk("rst busy", int'(busy), 0);
    chk("rst wt_cnt", int'(wt_cnt), 0);
    chk("rst dsn addr", int'(h_dsn_addra), 0);
    n0 = wr_data.size();
    repeat (3) @(negedge clk);
    chk("writes in reset", wr_data.size(), n0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle after reset", int'(busy), 0);
    chk("no writes after reset", wr_data.size(), n0);

    // Fresh conversion with a stray start while busy.
    build_exp();
    run("poke", 1'b1, lat);
    chk("poke lat", lat, 700);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
